// File: rtl/scc_pkg.sv
// Shared definitions for the data-memory controller: FSM states, the value
// returned to the core on a bus error, and the word-alignment helper.
package scc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] BUS_ERR_RDATA   = 32'h0000_0000;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

   function automatic logic is_aligned(input logic [31:0] addr);
      return ((addr & WORD_ALIGN_MASK) == 32'h0000_0000);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter for the REQ state; expired is high once the count
// reaches TIMEOUT-1, and the counter holds there rather than wrapping.
module wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_r;

   // count REQ cycles, saturating at the last value
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= CW'(0);
      end else if (clear) begin
         count_r <= CW'(0);
      end else if (en && !expired) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == LAST);

endmodule

// File: rtl/data_mem_ctrl.sv
// Core-to-memory data port controller: accepts one aligned read or write at a
// time, runs a level-request/ack memory handshake, and times out stalled accesses.
module data_mem_ctrl
   import scc_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_out,
   input  logic        data_read,
   input  logic        data_write,
   output logic [31:0] data_in,
   output logic        stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_req,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err
);

   state_t      state_r;
   state_t      state_s;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic        we_r;
   logic [31:0] rdata_r;
   logic        bus_err_r;
   logic        stall_s;
   logic        valid_req_s;
   logic        bad_req_s;
   logic        in_req_s;
   logic        expired_s;
   logic        timeout_s;

   assign valid_req_s = (data_read ^ data_write) && is_aligned(data_addr);
   assign bad_req_s   = (data_read && data_write) ||
                        ((data_read || data_write) && !is_aligned(data_addr));
   assign in_req_s    = (state_r == REQ);
   assign timeout_s   = in_req_s && !mem_ack && expired_s;

   // counter is held clear outside REQ, so it always starts from zero on entry
   wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!in_req_s),
      .en      (in_req_s && !mem_ack),
      .expired (expired_s)
   );

   // next-state and stall decode
   always_comb begin
      state_s = state_r;
      stall_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (valid_req_s) begin
               stall_s = 1'b1;
               state_s = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            stall_s = 1'b1;
            if (mem_ack || expired_s) begin
               state_s = DONE;
            end else begin
               state_s = REQ;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // state, request latches and error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         addr_r    <= 32'h0000_0000;
         wdata_r   <= 32'h0000_0000;
         we_r      <= 1'b0;
         bus_err_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         bus_err_r <= ((state_r == IDLE) && bad_req_s) || timeout_s;
         if ((state_r == IDLE) && valid_req_s) begin
            addr_r  <= data_addr;
            wdata_r <= data_out;
            we_r    <= data_write;
         end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            we_r    <= we_r;
         end
      end
   end

   // read register: updated only by a read ack or forced by a timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_r <= 32'h0000_0000;
      end else if (in_req_s && mem_ack && !we_r) begin
         rdata_r <= mem_rdata;
      end else if (timeout_s) begin
         rdata_r <= BUS_ERR_RDATA;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign stall     = stall_s;
   assign mem_req   = in_req_s;
   assign mem_we    = in_req_s && we_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign data_in   = rdata_r;
   assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: the stimulus thread queues expected
// transaction records; a negedge monitor pops and checks them on DUT events.
module tb_data_mem_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_addr;
   logic [31:0] data_out;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_in;
   logic        stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        bus_err;
   logic        probe = 1'b0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_addr  (data_addr),
      .data_out   (data_out),
      .data_read  (data_read),
      .data_write (data_write),
      .data_in    (data_in),
      .stall      (stall),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .bus_err    (bus_err)
   );

   typedef enum int {K_XFER = 0, K_ERR = 1, K_PROBE = 2} kind_t;

   typedef struct {
      kind_t       kind;
      int          req_cycles;
      int          stall_cycles;
      int          gap;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] data_in;
      logic        bus_err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(input kind_t k, input int rc, input int sc, input int g,
                               input logic [31:0] a, input logic [31:0] w, input logic we,
                               input logic [31:0] d, input logic be);
      exp_t e;
      e.kind = k; e.req_cycles = rc; e.stall_cycles = sc; e.gap = g;
      e.addr = a; e.wdata = w; e.we = we; e.data_in = d; e.bus_err = be;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: samples on the falling edge, away from DUT updates
   initial begin
      exp_t e;
      logic prev_req;
      int   req_cnt;
      int   stall_cnt;
      int   gap;
      prev_req = 1'b0; req_cnt = 0; stall_cnt = 0; gap = -1;
      forever begin
         @(negedge clk);
         if (stall === 1'b1) stall_cnt++;
         if (mem_req === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].kind == K_XFER) begin
               if (!prev_req && exp_q[0].gap >= 0) check("req_gap", 32'(gap), 32'(exp_q[0].gap));
               check("mem_addr", mem_addr, exp_q[0].addr);
               check("mem_we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
               if (exp_q[0].we) check("mem_wdata", mem_wdata, exp_q[0].wdata);
            end else begin
               check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
            end
            req_cnt++;
         end else if (prev_req) begin
            if (exp_q.size() == 0) begin
               check("unexpected_completion", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("done_kind", 32'(e.kind), 32'(K_XFER));
               check("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
               check("stall_cycles", 32'(stall_cnt), 32'(e.stall_cycles));
               check("done_stall", {31'd0, stall}, 32'd0);
               check("done_mem_we", {31'd0, mem_we}, 32'd0);
               check("done_data_in", data_in, e.data_in);
               check("done_bus_err", {31'd0, bus_err}, {31'd0, e.bus_err});
            end
            req_cnt = 0; stall_cnt = 0; gap = 0;
         end else begin
            if (gap >= 0) gap++;
            if (bus_err === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_bus_err", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("err_kind", 32'(e.kind), 32'(K_ERR));
                  check("err_stall_cycles", 32'(stall_cnt), 32'(e.stall_cycles));
                  check("err_data_in", data_in, e.data_in);
               end
               stall_cnt = 0;
            end else if (probe === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_probe", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("probe_kind", 32'(e.kind), 32'(K_PROBE));
                  check("probe_data_in", data_in, e.data_in);
                  check("probe_bus_err", {31'd0, bus_err}, 32'd0);
                  check("probe_mem_we", {31'd0, mem_we}, 32'd0);
                  check("probe_stall", {31'd0, stall}, 32'd0);
               end
               stall_cnt = 0;
            end
         end
         prev_req = mem_req;
      end
   end

   task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_after, input logic [31:0] rdata);
      int n;
      data_read = !wr; data_write = wr; data_addr = addr; data_out = wdata;
      n = 0;
      while (mem_req !== 1'b1 && n < 8) begin
         @(posedge clk); #1; n++;
      end
      check("accept_wait", {31'd0, mem_req}, 32'd1);
      n = 0;
      while (mem_req === 1'b1 && n < 64) begin
         mem_ack   = (n == ack_after);
         mem_rdata = (n == ack_after) ? rdata : 32'hDEAD_BEEF;
         @(posedge clk); #1; n++;
      end
      mem_ack = 1'b0; data_read = 1'b0; data_write = 1'b0;
      check("done_wait", {31'd0, mem_req}, 32'd0);
   endtask

   task automatic bad_req(input logic rd, input logic wr, input logic [31:0] addr);
      data_read = rd; data_write = wr; data_addr = addr; data_out = 32'h5555_AAAA;
      @(posedge clk); #1;
      data_read = 1'b0; data_write = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic do_probe();
      probe = 1'b1;
      @(posedge clk); #1;
      probe = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; data_addr = 32'h0; data_out = 32'h0; data_read = 1'b0;
      data_write = 1'b0; mem_rdata = 32'h0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      exp_q.push_back(mk(K_PROBE, 0, 0, -1, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 1'b0));
      do_probe();

      // read 0x100, ack in first REQ cycle
      exp_q.push_back(mk(K_XFER, 1, 2, -1, 32'h0000_0100, 32'h0, 1'b0, 32'hA5A5_0001, 1'b0));
      access(1'b0, 32'h0000_0100, 32'h0, 0, 32'hA5A5_0001);
      @(posedge clk); #1;

      // write 0x200 with three wait cycles; read data must stay unchanged
      exp_q.push_back(mk(K_XFER, 4, 5, -1, 32'h0000_0200, 32'hCAFE_F00D, 1'b1, 32'hA5A5_0001, 1'b0));
      access(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 3, 32'h1111_2222);
      @(posedge clk); #1;

      // misaligned read, then read+write together
      exp_q.push_back(mk(K_ERR, 0, 0, -1, 32'h0, 32'h0, 1'b0, 32'hA5A5_0001, 1'b1));
      bad_req(1'b1, 1'b0, 32'h0000_0103);
      exp_q.push_back(mk(K_ERR, 0, 0, -1, 32'h0, 32'h0, 1'b0, 32'hA5A5_0001, 1'b1));
      bad_req(1'b1, 1'b1, 32'h0000_0104);

      // timeout: no ack ever
      exp_q.push_back(mk(K_XFER, 16, 17, -1, 32'h0000_0300, 32'h0, 1'b0, 32'h0000_0000, 1'b1));
      access(1'b0, 32'h0000_0300, 32'h0, -1, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // back-to-back reads; second request already presented during DONE
      exp_q.push_back(mk(K_XFER, 1, 2, -1, 32'h0000_0000, 32'h0, 1'b0, 32'h1111_0000, 1'b0));
      exp_q.push_back(mk(K_XFER, 2, 3, 1, 32'h0000_0004, 32'h0, 1'b0, 32'h2222_0004, 1'b0));
      access(1'b0, 32'h0000_0000, 32'h0, 0, 32'h1111_0000);
      access(1'b0, 32'h0000_0004, 32'h0, 1, 32'h2222_0004);
      @(posedge clk); #1;

      // reset in the second REQ cycle, then a stray ack
      exp_q.push_back(mk(K_XFER, 2, 3, -1, 32'h0000_0400, 32'h0, 1'b0, 32'h0000_0000, 1'b0));
      data_read = 1'b1; data_addr = 32'h0000_0400;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; data_read = 1'b0;
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_0001;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      exp_q.push_back(mk(K_PROBE, 0, 0, -1, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 1'b0));
      do_probe();

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
